// File: rtl/bitop_rmw_seq_pkg.sv
// Shared types and helpers for the bit-instruction read-modify-write sequencer.
// Optional feature macro used by the sequencer: BITOP_RMW_WDOG_EN (memory-ack watchdog).
package bitop_rmw_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        EXEC = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [2:0] OP_GETBIT  = 3'b000;
    localparam logic [2:0] OP_NGETBIT = 3'b001;
    localparam logic [2:0] OP_SETBIT  = 3'b010;
    localparam logic [2:0] OP_NSETBIT = 3'b011;

    // bitops B operand: a single 1 so setbit is SET and nsetbit is RES
    localparam logic [15:0] BO_B_CONST = 16'h0001;

    // Set-type ops modify the byte and need a write-back
    function automatic logic is_set_op(input logic [2:0] op);
        return (op == OP_SETBIT) || (op == OP_NSETBIT);
    endfunction

    // Only the four bit opcodes are meaningful to this sequencer
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_GETBIT) || (op == OP_NGETBIT) || is_set_op(op);
    endfunction

endpackage

// File: rtl/bitop_rmw_seq_if.sv
// Command, memory, bitops and completion signals of the RMW sequencer.
// slave = the sequencer itself; master = decode/memory/bitops environment.
interface bitop_rmw_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_bit;
    logic [15:0] cmd_addr;

    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    logic [15:0] bo_a;
    logic [15:0] bo_b;
    logic [15:0] bo_c;
    logic [2:0]  bo_opp;
    logic [15:0] bo_out;
    logic [7:0]  bo_flags;

    logic        done_valid;
    logic [7:0]  done_result;
    logic [7:0]  done_flags;
    logic        done_flags_we;
    logic        done_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_bit, cmd_addr,
        output cmd_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output bo_a, bo_b, bo_c, bo_opp,
        input  bo_out, bo_flags,
        output done_valid, done_result, done_flags, done_flags_we, done_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_bit, cmd_addr,
        input  cmd_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  bo_a, bo_b, bo_c, bo_opp,
        output bo_out, bo_flags,
        input  done_valid, done_result, done_flags, done_flags_we, done_err
    );
endinterface

// File: rtl/bitop_rmw_seq_wdog.sv
// Memory-ack watchdog: counts cycles a request waits without an ack.
// Instantiated by bitop_rmw_seq only when BITOP_RMW_WDOG_EN is defined.
module bitop_rmw_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic busy,
    output logic expired
);
    // Compare against limit-1 so a request lasting exactly TIMEOUT_CYCLES
    // cycles expires on its last cycle; an ack that cycle clears busy and wins.
    localparam logic [7:0] LIMIT_M1 = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_r;

    // Wait counter: cleared on entry to a memory phase, saturating increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= 8'h00;
        end else if (clear) begin
            count_r <= 8'h00;
        end else if (busy && (count_r != 8'hFF)) begin
            count_r <= count_r + 8'h01;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = busy && (count_r == LIMIT_M1);
endmodule

// File: rtl/bitop_rmw_seq.sv
// Read-modify-write sequencer around the combinational bitops unit.
// Optional memory-ack watchdog compiled in with BITOP_RMW_WDOG_EN.
module bitop_rmw_seq
    import bitop_rmw_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    bitop_rmw_seq_if.slave    bus
);
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("bitop_rmw_seq: TIMEOUT_CYCLES must be 1..255");
    end

    state_t      state_r, next_state_s;
    logic [2:0]  op_r, bit_r;
    logic [15:0] addr_r;
    logic [7:0]  operand_r, result_r, flags_r;
    logic        cmd_ready_r, mem_req_r, mem_we_r;
    logic        done_valid_r, done_flags_we_r, done_err_r;
    logic [15:0] bo_b_r;
    logic        cmd_ready_d, mem_req_d, mem_we_d;
    logic        done_valid_d, done_flags_we_d, done_err_d;
    logic        accept_s, ack_s, tmo_s;
    logic        unused_bo_hi_s;

    assign accept_s       = bus.cmd_valid && cmd_ready_r;
    assign ack_s          = bus.mem_ack && mem_req_r;   // stray acks are ignored
    assign unused_bo_hi_s = ^bus.bo_out[15:8];

`ifdef BITOP_RMW_WDOG_EN
    logic wdog_clear_s, wdog_busy_s, wdog_expired_s;
    assign wdog_clear_s = (next_state_s != state_r) && ((next_state_s == RD) || (next_state_s == WR));
    assign wdog_busy_s  = mem_req_r && !bus.mem_ack;
    bitop_rmw_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wdog_clear_s),
        .busy    (wdog_busy_s),
        .expired (wdog_expired_s)
    );
    assign tmo_s = wdog_expired_s;
`else
    assign tmo_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = is_legal_op(bus.cmd_op) ? RD : DONE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD: begin
                if (ack_s)      next_state_s = EXEC;
                else if (tmo_s) next_state_s = DONE;
                else            next_state_s = RD;
            end
            EXEC:    next_state_s = is_set_op(op_r) ? WR : DONE;
            WR: begin
                if (ack_s || tmo_s) next_state_s = DONE;
                else                next_state_s = WR;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        cmd_ready_d     = (next_state_s == IDLE);
        mem_req_d       = (next_state_s == RD) || (next_state_s == WR);
        mem_we_d        = (next_state_s == WR);
        done_valid_d    = (next_state_s == DONE);
        done_flags_we_d = 1'b0;
        done_err_d      = 1'b0;
        if (next_state_s == DONE) begin
            case (state_r)
                IDLE:    done_err_d = 1'b1;             // illegal opcode
                RD, WR:  done_err_d = tmo_s;            // watchdog expiry
                EXEC:    done_flags_we_d = !is_set_op(op_r);
                default: done_err_d = 1'b0;
            endcase
        end else begin
            done_err_d = 1'b0;
        end
    end

    // Control output registers; async reset forces every output low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_r     <= 1'b0;
            mem_req_r       <= 1'b0;
            mem_we_r        <= 1'b0;
            done_valid_r    <= 1'b0;
            done_flags_we_r <= 1'b0;
            done_err_r      <= 1'b0;
            bo_b_r          <= 16'h0000;
        end else begin
            cmd_ready_r     <= cmd_ready_d;
            mem_req_r       <= mem_req_d;
            mem_we_r        <= mem_we_d;
            done_valid_r    <= done_valid_d;
            done_flags_we_r <= done_flags_we_d;
            done_err_r      <= done_err_d;
            bo_b_r          <= BO_B_CONST;
        end
    end

    // Command latch on accept; address stays put until the next accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r   <= 3'b000;
            bit_r  <= 3'b000;
            addr_r <= 16'h0000;
        end else if (accept_s) begin
            op_r   <= bus.cmd_op;
            bit_r  <= bus.cmd_bit;
            addr_r <= bus.cmd_addr;
        end else begin
            op_r   <= op_r;
            bit_r  <= bit_r;
            addr_r <= addr_r;
        end
    end

    // Operand capture from the read, result/flags capture in EXEC
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operand_r <= 8'h00;
            result_r  <= 8'h00;
            flags_r   <= 8'h00;
        end else if ((state_r == RD) && ack_s) begin
            operand_r <= bus.mem_rdata;
        end else if (state_r == EXEC) begin
            result_r  <= bus.bo_out[7:0];
            flags_r   <= bus.bo_flags;
        end else begin
            operand_r <= operand_r;
            result_r  <= result_r;
            flags_r   <= flags_r;
        end
    end

    assign bus.cmd_ready     = cmd_ready_r;
    assign bus.mem_req       = mem_req_r;
    assign bus.mem_we        = mem_we_r;
    assign bus.mem_addr      = addr_r;
    assign bus.mem_wdata     = result_r;
    assign bus.bo_a          = {8'h00, operand_r};
    assign bus.bo_b          = bo_b_r;
    assign bus.bo_c          = {13'b0_0000_0000_0000, bit_r};
    assign bus.bo_opp        = op_r;
    assign bus.done_valid    = done_valid_r;
    assign bus.done_result   = result_r;
    assign bus.done_flags    = flags_r;
    assign bus.done_flags_we = done_flags_we_r;
    assign bus.done_err      = done_err_r;
endmodule

// File: tb/tb_bitop_rmw_seq.sv
// Directed testbench for bitop_rmw_seq with a behavioural bitops stand-in.
// The watchdog step runs only when BITOP_RMW_WDOG_EN is defined.
module tb_bitop_rmw_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    bitop_rmw_seq_if bus();

    bitop_rmw_seq #(.TIMEOUT_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // bitops stand-in: get/nget read bit C of A, set/nset write B[0] / ~B[0] into bit C; Z in flags[6]
    logic [15:0] model_mask, model_res;
    always_comb begin
        model_mask = 16'h0001 << bus.bo_c[3:0];
        case (bus.bo_opp)
            3'b000:  model_res = (bus.bo_a >> bus.bo_c[3:0]) & 16'h0001;
            3'b001:  model_res = (~(bus.bo_a >> bus.bo_c[3:0])) & 16'h0001;
            3'b010:  model_res = (bus.bo_a & ~model_mask) | (bus.bo_b[0] ? model_mask : 16'h0000);
            3'b011:  model_res = (bus.bo_a & ~model_mask) | (bus.bo_b[0] ? 16'h0000 : model_mask);
            default: model_res = 16'h0000;
        endcase
        bus.bo_out   = model_res;
        bus.bo_flags = {1'b0, (model_res == 16'h0000), 6'b00_0000};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [2:0] op, input logic [2:0] b, input logic [15:0] a);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_bit   = b;
        bus.cmd_addr  = a;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_bit   = 3'b000;
        bus.cmd_addr  = 16'h0000;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;

        // Reset state
        #12;
        chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chk("rst_mem_req",   bus.mem_req, 1'b0);
        chk("rst_done",      bus.done_valid, 1'b0);
        chk("rst_bo_b",      bus.bo_b, 16'h0000);
        chk("rst_addr",      bus.mem_addr, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("ready_before_edge", bus.cmd_ready, 1'b0);
        step();
        chk("ready_after_edge", bus.cmd_ready, 1'b1);
        chk("bo_b_const",       bus.bo_b, 16'h0001);

        // Stray ack while idle is ignored
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("stray_ack_req",   bus.mem_req, 1'b0);
        chk("stray_ack_done",  bus.done_valid, 1'b0);
        chk("stray_ack_ready", bus.cmd_ready, 1'b1);

        // getbit bit 3 of 8'h08 at 16'h4000, ack in cycle 1
        accept(3'b000, 3'd3, 16'h4000);
        chk("g_req_c1",   bus.mem_req, 1'b1);
        chk("g_we_c1",    bus.mem_we, 1'b0);
        chk("g_addr_c1",  bus.mem_addr, 16'h4000);
        chk("g_ready_c1", bus.cmd_ready, 1'b0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h08;
        step();
        bus.mem_ack = 1'b0;
        chk("g_req_c2", bus.mem_req, 1'b0);
        chk("g_bo_a",   bus.bo_a, 16'h0008);
        chk("g_bo_c",   bus.bo_c, 16'h0003);
        chk("g_bo_opp", bus.bo_opp, 3'b000);
        step();
        chk("g_done_c3",  bus.done_valid, 1'b1);
        chk("g_result",   bus.done_result, 8'h01);
        chk("g_flags",    bus.done_flags, 8'h00);
        chk("g_flags_we", bus.done_flags_we, 1'b1);
        chk("g_err",      bus.done_err, 1'b0);
        chk("g_no_write", bus.mem_req, 1'b0);
        step();
        chk("g_done_c4",  bus.done_valid, 1'b0);
        chk("g_ready_c4", bus.cmd_ready, 1'b1);

        // setbit bit 7 of 8'h0F at 16'h1234 -> write 8'h8F, done in cycle 4
        accept(3'b010, 3'd7, 16'h1234);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h0F;
        step();
        bus.mem_ack = 1'b0;
        step();
        chk("s_req_c3",   bus.mem_req, 1'b1);
        chk("s_we_c3",    bus.mem_we, 1'b1);
        chk("s_wdata",    bus.mem_wdata, 8'h8F);
        chk("s_addr",     bus.mem_addr, 16'h1234);
        chk("s_done_c3",  bus.done_valid, 1'b0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("s_done_c4",  bus.done_valid, 1'b1);
        chk("s_flags_we", bus.done_flags_we, 1'b0);
        chk("s_err",      bus.done_err, 1'b0);
        chk("s_result",   bus.done_result, 8'h8F);
        chk("s_req_c4",   bus.mem_req, 1'b0);
        step();

        // nsetbit bit 0 of 8'hFF, read ack delayed 5 cycles -> done in cycle 9
        accept(3'b011, 3'd0, 16'h2222);
        for (int i = 1; i <= 5; i++) begin
            chk("n_req_wait", bus.mem_req, 1'b1);
            step();
        end
        chk("n_req_c6", bus.mem_req, 1'b1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hFF;
        step();
        bus.mem_ack = 1'b0;
        chk("n_req_c7", bus.mem_req, 1'b0);
        step();
        chk("n_we_c8",    bus.mem_we, 1'b1);
        chk("n_wdata",    bus.mem_wdata, 8'hFE);
        chk("n_addr",     bus.mem_addr, 16'h2222);
        chk("n_done_c8",  bus.done_valid, 1'b0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("n_done_c9",  bus.done_valid, 1'b1);
        chk("n_flags_we", bus.done_flags_we, 1'b0);
        chk("n_err",      bus.done_err, 1'b0);
        step();
        chk("n_done_c10", bus.done_valid, 1'b0);

        // Illegal op 3'b101 -> error completion in cycle 1, no memory access
        accept(3'b101, 3'd2, 16'h3333);
        chk("i_done_c1",  bus.done_valid, 1'b1);
        chk("i_err",      bus.done_err, 1'b1);
        chk("i_flags_we", bus.done_flags_we, 1'b0);
        chk("i_req",      bus.mem_req, 1'b0);
        chk("i_ready_c1", bus.cmd_ready, 1'b0);

        // Back-to-back: ngetbit bit 2 of 8'h04 offered during DONE, taken once IDLE returns
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'b001; bus.cmd_bit = 3'd2; bus.cmd_addr = 16'h0055;
        step();
        chk("b_ready_c2", bus.cmd_ready, 1'b1);
        chk("b_req_c2",   bus.mem_req, 1'b0);
        chk("b_done_c2",  bus.done_valid, 1'b0);
        step();
        bus.cmd_valid = 1'b0;
        chk("b_req_c1",  bus.mem_req, 1'b1);
        chk("b_addr_c1", bus.mem_addr, 16'h0055);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h04;
        step();
        bus.mem_ack = 1'b0;
        step();
        chk("b_done_c3",  bus.done_valid, 1'b1);
        chk("b_result",   bus.done_result, 8'h00);
        chk("b_flags_z",  bus.done_flags, 8'h40);
        chk("b_flags_we", bus.done_flags_we, 1'b1);
        step();

`ifdef BITOP_RMW_WDOG_EN
        // Never ack: request held exactly 4 cycles, then error completion
        accept(3'b000, 3'd1, 16'h7777);
        for (int i = 1; i <= 4; i++) begin
            chk("w_req_hold", bus.mem_req, 1'b1);
            step();
        end
        chk("w_req_c5",   bus.mem_req, 1'b0);
        chk("w_done_c5",  bus.done_valid, 1'b1);
        chk("w_err",      bus.done_err, 1'b1);
        chk("w_flags_we", bus.done_flags_we, 1'b0);
        step();
`endif

        // Reset while in WR: request drops at once, no completion, ready one edge after release
        accept(3'b010, 3'd1, 16'h00AA);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h00;
        step();
        bus.mem_ack = 1'b0;
        step();
        chk("r_req_wr", bus.mem_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_req_async", bus.mem_req, 1'b0);
        chk("r_ready",     bus.cmd_ready, 1'b0);
        chk("r_addr",      bus.mem_addr, 16'h0000);
        step();
        chk("r_done_a", bus.done_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("r_ready_pre", bus.cmd_ready, 1'b0);
        step();
        chk("r_ready_post", bus.cmd_ready, 1'b1);
        chk("r_done_b",     bus.done_valid, 1'b0);
        chk("r_req_post",   bus.mem_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
